regfile_2w: RTL and testbench

Parametrised two-write-port register file for the multicycle ARM datapath. It replaces the single-write-port register file so a result and a base-register writeback (e.g. LDR/STR with writeback) can retire in the same cycle. It adds asynchronous clearing, optional same-cycle write-to-read bypass, write-collision detection and a per-register busy scoreboard for in-flight multicycle results. Index NREGS-1 is the PC alias, supplied externally on `r15`.

---
 rtl/regfile_2w.sv | 135 +++++++++++++
 tb/tb_regfile_2w.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_2w.sv
// rtl/regfile_2w.sv - two-write-port register file with PC alias, optional bypass,
// write-collision flag and per-register busy scoreboard.
module regfile_2w #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int AW     = 4,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we4,
  input  logic [AW-1:0]    wa4,
  input  logic [WIDTH-1:0] wd4,
  input  logic             we5,
  input  logic [AW-1:0]    wa5,
  input  logic [WIDTH-1:0] wd5,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [AW-1:0]    ra3,
  input  logic [WIDTH-1:0] r15,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  input  logic             bset,
  input  logic [AW-1:0]    bsa,
  output logic             busy1,
  output logic             busy2,
  output logic             busy3,
  output logic             wcol
);

  localparam int            NPHYS   = NREGS - 1;
  localparam logic [AW:0]   NPHYS_W = (AW+1)'(NPHYS);
  localparam logic [AW-1:0] PC_IDX  = AW'(NREGS - 1);

  // True only for indices backed by physical storage (excludes PC alias and out-of-range).
  function automatic logic in_phys(input logic [AW-1:0] a);
    return ({1'b0, a} < NPHYS_W);
  endfunction

  logic [WIDTH-1:0] regs_q [NPHYS];
  logic [WIDTH-1:0] regs_d [NPHYS];
  logic [NPHYS-1:0] busy_q;
  logic [NPHYS-1:0] busy_d;
  logic             wcol_q;
  logic             wcol_d;

  logic wr4_ok;
  logic wr5_ok;
  logic bset_ok;

  assign wr4_ok  = we4 && in_phys(wa4);
  assign wr5_ok  = we5 && in_phys(wa5);
  assign bset_ok = bset && in_phys(bsa);

  // Port 5 is applied after port 4 so it wins a collision; bset is applied last so it
  // wins over the write-side busy clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    wcol_d = wr4_ok && wr5_ok && (wa4 == wa5);
    for (int i = 0; i < NPHYS; i++) begin
      if (wr4_ok && (wa4 == AW'(i))) begin
        regs_d[i] = wd4;
        busy_d[i] = 1'b0;
      end
      if (wr5_ok && (wa5 == AW'(i))) begin
        regs_d[i] = wd5;
        busy_d[i] = 1'b0;
      end
      if (bset_ok && (bsa == AW'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPHYS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      wcol_q <= 1'b0;
    end else begin
      for (int i = 0; i < NPHYS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
      wcol_q <= wcol_d;
    end
  end

  assign wcol = wcol_q;

  logic [AW-1:0] ra_v [3];
  assign ra_v[0] = ra1;
  assign ra_v[1] = ra2;
  assign ra_v[2] = ra3;

  for (genvar p = 0; p < 3; p++) begin : g_rd
    logic [WIDTH-1:0] rd_p;
    logic             busy_p;

    always_comb begin
      rd_p   = '0;
      busy_p = 1'b0;
      for (int i = 0; i < NPHYS; i++) begin
        if (ra_v[p] == AW'(i)) begin
          rd_p   = regs_q[i];
          busy_p = busy_q[i];
        end
      end
      if (ra_v[p] == PC_IDX) begin
        rd_p = r15;
      end
      // Forwarding only touches data; busy always reflects the registered scoreboard.
      if ((BYPASS != 0) && in_phys(ra_v[p])) begin
        if (we4 && (wa4 == ra_v[p])) begin
          rd_p = wd4;
        end
        if (we5 && (wa5 == ra_v[p])) begin
          rd_p = wd5;
        end
      end
    end
  end

  assign rd1   = g_rd[0].rd_p;
  assign rd2   = g_rd[1].rd_p;
  assign rd3   = g_rd[2].rd_p;
  assign busy1 = g_rd[0].busy_p;
  assign busy2 = g_rd[1].busy_p;
  assign busy3 = g_rd[2].busy_p;

endmodule

// File: tb/tb_regfile_2w.sv
// tb/tb_regfile_2w.sv - bench for regfile_2w: a BYPASS=1/NREGS=16 instance and a
// BYPASS=0/NREGS=12 instance share stimulus; the second exposes PC=11 and out-of-range 12..15.
module tb_regfile_2w;

  logic        clk;
  logic        reset_n;
  logic        we4;
  logic [3:0]  wa4;
  logic [31:0] wd4;
  logic        we5;
  logic [3:0]  wa5;
  logic [31:0] wd5;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [3:0]  ra3;
  logic [31:0] r15;
  logic        bset;
  logic [3:0]  bsa;

  logic [31:0] b_rd1, b_rd2, b_rd3;
  logic        b_busy1, b_busy2, b_busy3, b_wcol;
  logic [31:0] n_rd1, n_rd2, n_rd3;
  logic        n_busy1, n_busy2, n_busy3, n_wcol;

  regfile_2w #(.WIDTH(32), .NREGS(16), .AW(4), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .we5(we5), .wa5(wa5), .wd5(wd5),
    .ra1(ra1), .ra2(ra2), .ra3(ra3), .r15(r15),
    .rd1(b_rd1), .rd2(b_rd2), .rd3(b_rd3),
    .bset(bset), .bsa(bsa),
    .busy1(b_busy1), .busy2(b_busy2), .busy3(b_busy3),
    .wcol(b_wcol)
  );

  regfile_2w #(.WIDTH(32), .NREGS(12), .AW(4), .BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n),
    .we4(we4), .wa4(wa4), .wd4(wd4),
    .we5(we5), .wa5(wa5), .wd5(wd5),
    .ra1(ra1), .ra2(ra2), .ra3(ra3), .r15(r15),
    .rd1(n_rd1), .rd2(n_rd2), .rd3(n_rd3),
    .bset(bset), .bsa(bsa),
    .busy1(n_busy1), .busy2(n_busy2), .busy3(n_busy3),
    .wcol(n_wcol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we4;
    logic [3:0]  wa4;
    logic [31:0] wd4;
    logic        we5;
    logic [3:0]  wa5;
    logic [31:0] wd5;
    logic        bset;
    logic [3:0]  bsa;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  ra3;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_rd3;
    logic [31:0] e_nrd2;
    logic        e_busy1;
    logic        e_busy3;
    logic        e_nbusy2;
    logic        e_wcol;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];
  vec_t exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    we4  = v.we4;  wa4 = v.wa4;  wd4 = v.wd4;
    we5  = v.we5;  wa5 = v.wa5;  wd5 = v.wd5;
    bset = v.bset; bsa = v.bsa;
    ra1  = v.ra1;  ra2 = v.ra2;  ra3 = v.ra3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    vec_t e;
    // Each row: inputs held for one cycle, and outputs expected in that same cycle before its edge.
    //            we4   wa4    wd4           we5   wa5    wd5           bset  bsa    ra1    ra2    ra3    rd1           rd2           rd3           nb_rd2        bsy1  bsy3  nbsy2 wcol
    tbl[0]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd0,  4'd0,  4'd15, 32'h0,        32'h0,        32'h8000,     32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd2,  32'h11,       1'b1, 4'd5,  32'h22,       1'b0, 4'd0,  4'd2,  4'd5,  4'd15, 32'h11,       32'h22,       32'h8000,     32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd2,  4'd5,  4'd15, 32'h11,       32'h22,       32'h8000,     32'h22,       1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'd7,  32'hAAAA,     1'b1, 4'd7,  32'h5555,     1'b0, 4'd0,  4'd7,  4'd7,  4'd2,  32'h5555,     32'h5555,     32'h11,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd7,  4'd7,  4'd2,  32'h5555,     32'h5555,     32'h11,       32'h5555,     1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd7,  4'd7,  4'd2,  32'h5555,     32'h5555,     32'h11,       32'h5555,     1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'd4,  32'h1234,     1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd2,  4'd4,  4'd5,  32'h11,       32'h1234,     32'h22,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd2,  4'd4,  4'd5,  32'h11,       32'h1234,     32'h22,       32'h1234,     1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'd15, 32'h99,       1'b1, 4'd15, 32'h77,       1'b1, 4'd15, 4'd15, 4'd15, 4'd15, 32'h8000,     32'h8000,     32'h8000,     32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd15, 4'd15, 4'd15, 32'h8000,     32'h8000,     32'h8000,     32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd11, 32'hBB,       1'b0, 4'd0,  4'd0,  4'd11, 4'd0,  32'h0,        32'hBB,       32'h0,        32'h8000,     1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd0,  4'd11, 4'd0,  32'h0,        32'hBB,       32'h0,        32'h8000,     1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd6,  4'd6,  4'd6,  4'd6,  32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd6,  4'd6,  4'd6,  32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 4'd6,  32'h66,       1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd6,  4'd6,  4'd6,  32'h66,       32'h66,       32'h66,       32'h0,        1'b1, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd6,  4'd6,  4'd6,  32'h66,       32'h66,       32'h66,       32'h66,       1'b0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd6,  32'h67,       1'b1, 4'd6,  4'd6,  4'd6,  4'd6,  32'h67,       32'h67,       32'h67,       32'h66,       1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd6,  4'd6,  4'd6,  32'h67,       32'h67,       32'h67,       32'h67,       1'b1, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b1, 4'd11, 4'd6,  4'd11, 4'd11, 32'h67,       32'hBB,       32'hBB,       32'h8000,     1'b1, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  32'h0,        1'b0, 4'd0,  4'd6,  4'd11, 4'd11, 32'h67,       32'hBB,       32'hBB,       32'h8000,     1'b1, 1'b1, 1'b0, 1'b0};

    reset_n = 1'b0;
    r15     = 32'h8000;
    drive(tbl[0]);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(tbl[k]);
      exp_q.push_back(tbl[k]);
      #2;
      if (exp_q.size() == 0) begin
        chk($sformatf("v%0d_queue", k), 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d_rd1", k),    b_rd1,   e.e_rd1);
        chk($sformatf("v%0d_rd2", k),    b_rd2,   e.e_rd2);
        chk($sformatf("v%0d_rd3", k),    b_rd3,   e.e_rd3);
        chk($sformatf("v%0d_nb_rd2", k), n_rd2,   e.e_nrd2);
        chk($sformatf("v%0d_busy1", k),  32'(b_busy1), 32'(e.e_busy1));
        chk($sformatf("v%0d_busy3", k),  32'(b_busy3), 32'(e.e_busy3));
        chk($sformatf("v%0d_nb_busy2", k), 32'(n_busy2), 32'(e.e_nbusy2));
        chk($sformatf("v%0d_wcol", k),   32'(b_wcol), 32'(e.e_wcol));
        chk($sformatf("v%0d_nb_wcol", k), 32'(n_wcol), 32'(e.e_wcol));
      end
    end

    // Asynchronous reset mid-cycle after a colliding write plus busy mark on r3.
    @(negedge clk);
    we4 = 1'b1; wa4 = 4'd3; wd4 = 32'hDEADBEEF;
    we5 = 1'b1; wa5 = 4'd3; wd5 = 32'hDEADBEEF;
    bset = 1'b1; bsa = 4'd3;
    ra1 = 4'd3; ra2 = 4'd3; ra3 = 4'd0;
    @(posedge clk);
    #1;
    we4 = 1'b0; we5 = 1'b0; bset = 1'b0;
    #1;
    chk("pre_rst_rd1",    b_rd1, 32'hDEADBEEF);
    chk("pre_rst_nb_rd2", n_rd2, 32'hDEADBEEF);
    chk("pre_rst_busy1",  32'(b_busy1), 32'd1);
    chk("pre_rst_wcol",   32'(b_wcol), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_rd1",    b_rd1, 32'h0);
    chk("rst_nb_rd2", n_rd2, 32'h0);
    chk("rst_busy1",  32'(b_busy1), 32'd0);
    chk("rst_wcol",   32'(b_wcol), 32'd0);

    // Writes and bset presented under reset must not land.
    we4 = 1'b1; wa4 = 4'd3; wd4 = 32'h42;
    bset = 1'b1; bsa = 4'd3;
    @(posedge clk);
    #1;
    chk("rst_hold_nb_rd2",   n_rd2, 32'h0);
    chk("rst_hold_nb_busy2", 32'(n_busy2), 32'd0);
    chk("rst_hold_busy1",    32'(b_busy1), 32'd0);

    // First edge after release writes without any sync cycles.
    @(negedge clk);
    reset_n = 1'b1;
    bset = 1'b0;
    @(posedge clk);
    #1;
    we4 = 1'b0;
    #1;
    chk("post_rst_rd1",    b_rd1, 32'h42);
    chk("post_rst_nb_rd2", n_rd2, 32'h42);
    chk("post_rst_wcol",   32'(b_wcol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
